// File: rtl/simon_pkg.sv
// Shared Simon Says definitions: playback states, speed width, colour decode.
// No ports; imported by the player, its interface and the input checker.
package simon_pkg;

    localparam int SPEED_W = 2;

    typedef enum logic [2:0] {
        P_IDLE,
        P_FETCH,
        P_LATCH,
        P_ON,
        P_OFF,
        P_FINISH
    } player_state_e;

    function automatic logic [3:0] colour_onehot(input logic [1:0] c);
        logic [3:0] r;
        unique case (c)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            default: r = 4'b1000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sequence_player_if.sv
// Control, memory-read and LED bundle of the sequence player.
// master: game FSM / memory side; slave: the player itself.
interface sequence_player_if #(
    parameter int ROUND_W = 6
);
    import simon_pkg::*;

    logic                start;
    logic                abort;
    logic [ROUND_W-1:0]  current_round;
    logic [SPEED_W-1:0]  speed;
    logic [ROUND_W-1:0]  mem_addr;
    logic [1:0]          mem_data;
    logic [3:0]          led;
    logic                pulse;
    logic                busy;
    logic                done;

    modport master (
        output start, abort, current_round, speed, mem_data,
        input  mem_addr, led, pulse, busy, done
    );

    modport slave (
        input  start, abort, current_round, speed, mem_data,
        output mem_addr, led, pulse, busy, done
    );

endinterface

// File: rtl/sequence_player_step_timer.sv
// Loadable down-counter shared by the LED-on and LED-off phases.
// Ports: clk, reset (async, active-low), load, load_val, zero flag.
module step_timer #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Holds at zero once expired; a new load restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays pattern entries 0..N-1 as timed one-hot LED flashes.
// Ports: clk, reset (async, active-low), bus (sequence_player_if.slave).
module sequence_player
    import simon_pkg::*;
#(
    parameter int ROUND_W  = 6,
    parameter int BASE_ON  = 25_000_000,
    parameter int BASE_OFF = 12_500_000,
    parameter int CNT_W    = 25
) (
    input  logic                clk,
    input  logic                reset,
    sequence_player_if.slave    bus
);

    player_state_e      state;
    logic [ROUND_W-1:0] idx;
    logic [ROUND_W-1:0] n_r;
    logic [CNT_W-1:0]   on_t;
    logic [CNT_W-1:0]   off_t;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_zero;

    // Speed scales durations down; never let a phase vanish.
    function automatic logic [CNT_W-1:0] scaled(
        input int                 base,
        input logic [SPEED_W-1:0] sp
    );
        int v;
        v = base >> sp;
        if (v < 1) v = 1;
        return CNT_W'(v);
    endfunction

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = on_t - CNT_W'(1);
        if (state == P_LATCH) begin
            tmr_load = 1'b1;
        end else if (state == P_ON && tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = off_t - CNT_W'(1);
        end
    end

    step_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Outputs are set together with the state they belong to,
    // so led/pulse/done come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= P_IDLE;
            idx          <= '0;
            n_r          <= '0;
            on_t         <= '0;
            off_t        <= '0;
            bus.mem_addr <= '0;
            bus.led      <= '0;
            bus.pulse    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.pulse <= 1'b0;
            bus.done  <= 1'b0;
            if (bus.abort && state != P_IDLE) begin
                state    <= P_IDLE;
                bus.led  <= '0;
                bus.busy <= 1'b0;
            end else begin
                unique case (state)
                    P_IDLE: begin
                        if (bus.start) begin
                            n_r          <= bus.current_round;
                            on_t         <= scaled(BASE_ON, bus.speed);
                            off_t        <= scaled(BASE_OFF, bus.speed);
                            idx          <= '0;
                            bus.mem_addr <= '0;
                            bus.busy     <= 1'b1;
                            if (bus.current_round == '0) begin
                                state    <= P_FINISH;
                                bus.done <= 1'b1;
                            end else begin
                                state <= P_FETCH;
                            end
                        end
                    end
                    P_FETCH: begin
                        state <= P_LATCH;
                    end
                    P_LATCH: begin
                        bus.led   <= colour_onehot(bus.mem_data);
                        bus.pulse <= 1'b1;
                        state     <= P_ON;
                    end
                    P_ON: begin
                        if (tmr_zero) begin
                            bus.led <= '0;
                            state   <= P_OFF;
                        end
                    end
                    P_OFF: begin
                        if (tmr_zero) begin
                            if (idx == n_r - ROUND_W'(1)) begin
                                state    <= P_FINISH;
                                bus.done <= 1'b1;
                            end else begin
                                idx          <= idx + ROUND_W'(1);
                                bus.mem_addr <= idx + ROUND_W'(1);
                                state        <= P_FETCH;
                            end
                        end
                    end
                    P_FINISH: begin
                        state    <= P_IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state    <= P_IDLE;
                        bus.led  <= '0;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: per-cycle schedule model plus literal timing checks.
// Drives the interface as master and models the synchronous pattern memory.
module tb_sequence_player;

    localparam int ROUND_W  = 6;
    localparam int BASE_ON  = 4;
    localparam int BASE_OFF = 2;
    localparam int CNT_W    = 8;
    localparam int LIMIT    = 2000;

    typedef struct packed {
        logic [3:0] led;
        logic       pulse;
        logic       busy;
        logic       done;
        logic       chk_addr;
        logic [5:0] addr;
    } exp_t;

    logic clk;
    logic reset;
    logic [1:0] mem [64];

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    exp_t cur;
    int   pc_q[$];
    int   addr_q[$];

    sequence_player_if #(.ROUND_W(ROUND_W)) bus ();

    sequence_player #(
        .ROUND_W  (ROUND_W),
        .BASE_ON  (BASE_ON),
        .BASE_OFF (BASE_OFF),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

    function automatic exp_t mk(input logic [3:0] l, input logic p,
                                input logic b, input logic d,
                                input logic ca, input logic [5:0] a);
        exp_t e;
        e.led = l; e.pulse = p; e.busy = b; e.done = d;
        e.chk_addr = ca; e.addr = a;
        return e;
    endfunction

    // Expected per-cycle trace of a whole playback, built at start.
    task automatic schedule(input int n, input int sp);
        int on_c;
        int off_c;
        on_c  = BASE_ON >> sp;
        off_c = BASE_OFF >> sp;
        if (on_c < 1) on_c = 1;
        if (off_c < 1) off_c = 1;
        for (int i = 0; i < n; i++) begin
            q.push_back(mk(4'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'(i)));
            q.push_back(mk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0));
            for (int j = 0; j < on_c; j++)
                q.push_back(mk(4'b0001 << mem[i], j == 0, 1'b1, 1'b0, 1'b0, 6'd0));
            for (int j = 0; j < off_c; j++)
                q.push_back(mk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0));
        end
        q.push_back(mk(4'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0));
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            cur = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        end else if (cur.busy) begin
            if (bus.abort) begin
                q.delete();
                cur = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            end
        end else if (bus.start) begin
            schedule(int'(bus.current_round), int'(bus.speed));
            cur = q.pop_front();
        end else begin
            cur = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        end
    end

    always @(negedge clk) begin
        checks++;
        if (bus.led !== cur.led || bus.pulse !== cur.pulse ||
            bus.busy !== cur.busy || bus.done !== cur.done ||
            (cur.chk_addr && bus.mem_addr !== cur.addr)) begin
            errors++;
            $display("FAIL cycle t=%0t led %b want %b pulse %b want %b busy %b want %b done %b want %b addr %0d want %0d",
                     $time, bus.led, cur.led, bus.pulse, cur.pulse,
                     bus.busy, cur.busy, bus.done, cur.done,
                     bus.mem_addr, cur.addr);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Cycle c is the one following clock edge c-1; the start edge is edge 0.
    task automatic play(input logic [5:0] n, input logic [1:0] sp,
                        input int poke, input int abort_at,
                        output int done_cyc, output int busy_cyc);
        int c;
        pc_q.delete();
        addr_q.delete();
        done_cyc = -1;
        busy_cyc = 0;
        @(negedge clk);
        bus.current_round = n;
        bus.speed = sp;
        bus.start = 1'b1;
        c = 0;
        while (done_cyc < 0 && c < LIMIT &&
               !(abort_at > 0 && c > abort_at + 8)) begin
            @(negedge clk);
            c++;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (bus.busy) busy_cyc++;
            if (bus.pulse) pc_q.push_back(c);
            if (bus.busy && (addr_q.size() == 0 ||
                             addr_q[addr_q.size()-1] != int'(bus.mem_addr)))
                addr_q.push_back(int'(bus.mem_addr));
            if (bus.done) done_cyc = c;
            if (abort_at > 0 && c == abort_at + 1) begin
                check("abort_busy", 32'(bus.busy), 32'd0);
                check("abort_led", 32'(bus.led), 32'd0);
            end
            if (c == poke) begin
                bus.start = 1'b1;
                bus.current_round = n + 6'd5;
                bus.speed = ~sp;
            end
            if (c == abort_at) bus.abort = 1'b1;
        end
        if (abort_at == 0 && done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout no done within %0d cycles", LIMIT);
        end
    endtask

    function automatic int at(input int idx);
        return (idx < pc_q.size()) ? pc_q[idx] : -1;
    endfunction

    function automatic int ad(input int idx);
        return (idx < addr_q.size()) ? addr_q[idx] : -1;
    endfunction

    initial begin
        int dc;
        int bc;
        clk = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.current_round = '0;
        bus.speed = '0;
        for (int i = 0; i < 64; i++) mem[i] = 2'd0;
        mem[0] = 2'd2;
        mem[1] = 2'd0;
        mem[2] = 2'd3;
        #1 reset = 1'b0;
        #2;
        check("rst_led", 32'(bus.led), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pulse", 32'(bus.pulse), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        play(6'd3, 2'd0, 0, 0, dc, bc);
        check("s0_done", 32'(dc), 32'd25);
        check("s0_npulse", 32'(pc_q.size()), 32'd3);
        check("s0_p0", 32'(at(0)), 32'd3);
        check("s0_p1", 32'(at(1)), 32'd11);
        check("s0_p2", 32'(at(2)), 32'd19);
        check("s0_naddr", 32'(addr_q.size()), 32'd3);
        check("s0_a0", 32'(ad(0)), 32'd0);
        check("s0_a1", 32'(ad(1)), 32'd1);
        check("s0_a2", 32'(ad(2)), 32'd2);

        play(6'd3, 2'd1, 0, 0, dc, bc);
        check("s1_done", 32'(dc), 32'd16);
        play(6'd3, 2'd2, 0, 0, dc, bc);
        check("s2_done", 32'(dc), 32'd13);

        play(6'd0, 2'd0, 0, 0, dc, bc);
        check("n0_done", 32'(dc), 32'd1);
        check("n0_busy", 32'(bc), 32'd1);
        check("n0_npulse", 32'(pc_q.size()), 32'd0);

        play(6'd3, 2'd0, 0, 11, dc, bc);
        check("abort_nodone", 32'(dc), 32'hFFFF_FFFF);
        play(6'd3, 2'd0, 0, 0, dc, bc);
        check("replay_a0", 32'(ad(0)), 32'd0);
        check("replay_done", 32'(dc), 32'd25);

        play(6'd3, 2'd0, 5, 0, dc, bc);
        check("poke_done", 32'(dc), 32'd25);
        check("poke_npulse", 32'(pc_q.size()), 32'd3);

        @(negedge clk);
        bus.current_round = 6'd3;
        bus.speed = 2'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_led", 32'(bus.led), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
        play(6'd63, 2'd2, 0, 0, dc, bc);
        check("n63_done", 32'(dc), 32'd253);
        check("n63_naddr", 32'(addr_q.size()), 32'd63);
        check("n63_last", 32'(ad(62)), 32'd62);

        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 9) == 0);
            bus.abort = ($urandom_range(0, 39) == 0);
            bus.current_round = 6'($urandom_range(0, 5));
            bus.speed = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
Playback controller for the Simon Says pattern store. On a start request from the game FSM, it reads entries 0..current_round-1 from the pattern memory. Each entry is shown on the 4 LEDs as a one-hot flash with timed on/off gaps. It emits one pulse per flash to the game FSM and a done strobe at the end. It sits between the game FSM, the pattern memory and the LED outputs, and is the only master of the memory read port during playback.

Parameters:
ROUND_W, 6, width of round count and memory address
BASE_ON, 25_000_000, LED-on cycles per step at speed 0
BASE_OFF, 12_500_000, LED-off gap cycles per step at speed 0
CNT_W, 25, width of the duration counter; must hold BASE_ON

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset; 0 clears all state
start  in  1  one-cycle playback request from game FSM
abort  in  1  cancel playback, return to IDLE
current_round  in  ROUND_W  number of entries to play (N)
speed  in  2  playback speed; durations are right-shifted by speed
mem_addr  out  ROUND_W  pattern memory read address
mem_data  in  2  colour index; valid one cycle after mem_addr (synchronous read)
led  out  4  one-hot LED drive; 0 when dark
pulse  out  1  one cycle high on the first cycle of each LED-on phase
busy  out  1  high in every state except IDLE
done  out  1  one cycle high when playback completes

Behaviour:
- Reset (reset=0, async): state=IDLE, led=0, pulse=0, busy=0, done=0, mem_addr=0, step index=0, counter=0.
- States: IDLE, FETCH, LATCH, ON, OFF, FINISH.
- IDLE: on start=1, capture N=current_round and on_t=max(BASE_ON>>speed,1), off_t=max(BASE_OFF>>speed,1). Go to FETCH with index=0. If N==0, go straight to FINISH.
- Inputs are sampled only at start. Changes to current_round or speed during playback have no effect.
- FETCH (1 cycle): mem_addr=index. Go to LATCH.
- LATCH (1 cycle): register mem_data and decode it to one-hot (0->0001, 1->0010, 2->0100, 3->1000). Load counter=on_t-1. Go to ON.
- ON: led=decoded value. pulse=1 only in the first ON cycle. Count down; at 0, load off_t-1 and go to OFF.
- OFF: led=0. Count down; at 0, if index==N-1 go to FINISH, else index+1 and go to FETCH.
- FINISH (1 cycle): done=1, busy=1. Return to IDLE.
- Timing: step period = 2+on_t+off_t cycles. Latency from the start-sampling edge to the done cycle = 1+N*(2+on_t+off_t), or 1 cycle for N==0.
- start while busy: ignored.
- abort=1 in any non-IDLE state: next cycle is IDLE with led=0, and done/pulse are not asserted. abort has priority over all other transitions, including FINISH. In IDLE, abort is ignored; if abort and start are both high in IDLE, start wins.
- N = 2^ROUND_W-1 (63): the index never wraps and the last address is 62.
- Outputs are registered. led, pulse and done are glitch-free.
- Reset asserted mid-playback: immediate return to reset values, no done.

Decomposition:
- Shared package simon_pkg: player_state_e enum; the colour-to-one-hot decode function (also used by the input checker); speed width constant.
- One sub-module, step_timer: a loadable down-counter with load value, load strobe and a zero flag, reused for the on and off phases. All other logic sits in sequence_player.

Test Plan:
- BASE_ON=4, BASE_OFF=2, speed=0, N=3, memory {2,0,3}, start at edge 0 -> led shows 0100, 0001, 1000, each for 4 cycles with 2-cycle gaps; 3 pulses at cycles 3, 11, 19; done at cycle 25; mem_addr sequence 0,1,2.
- Same stimulus with speed=1 -> on_t=2, off_t=1; done at cycle 16. With speed=2 -> on_t=1, off_t=1 (clamped); done at cycle 13.
- N=0 then start -> no pulse, led stays 0, done at cycle 1, busy high for exactly 1 cycle.
- abort during second ON phase -> led=0 and busy=0 the next cycle, no done; a fresh start afterwards replays from address 0.
- start re-asserted while busy, plus current_round changed mid-run -> ignored; playback uses the originally captured N and done timing is unchanged.
- reset driven low mid-OFF between clock edges -> outputs clear asynchronously before the next edge; after release, IDLE with busy=0.
